imem_loadable: RTL and testbench
================================

// Module: imem_loadable
// PURPOSE
//  Parametrised instruction memory for the single-cycle RISC-V core; word array of DEPTH x XLEN.
//  Loaded at run time over a valid/ready stream port instead of hard-coded writes.
//  Byte-addressed fetch port driven by the PC, with alignment and range fault flags.
//  Sits between PC register and decoder; the loader port is driven by the testbench or boot ROM.
// PARAMETERS
//  DEPTH          64   number of XLEN-bit words; power of two, >=4
//  XLEN           32   instruction word width
//  ADDR_W         32   fetch byte-address width
//  REG_READ       0    0 = combinational fetch; 1 = one-cycle registered fetch
//  CLEAR_ON_RESET 1    1 = zero all words after reset (DEPTH cycles); 0 = skip to LOAD
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       reset: synchronous, active-high
//  fetch_addr     in   ADDR_W  byte address from PC
//  instr          out  XLEN    fetched instruction
//  instr_valid    out  1       instr is valid (state RUN, no fault)
//  fault_misalign out  1       fetch_addr[1:0] != 0
//  fault_range    out  1       fetch_addr >= DEPTH*4
//  parity_err     out  1       stored-word parity mismatch (0 when IMEM_PARITY_EN undefined)
//  load_start     in   1       pulse: restart loading at word 0 (honoured in RUN only)
//  load_valid     in   1       load beat valid
//  load_ready     out  1       load beat accepted when valid&&ready
//  load_data      in   XLEN    word to write
//  load_last      in   1       final beat of program
//  busy           out  1       state CLEAR or LOAD
// BEHAVIOUR
//  States: CLEAR -> LOAD -> RUN; reset forces CLEAR (CLEAR_ON_RESET=1) else LOAD; ptr=0.
//  Reset outputs: instr=NOP (32'h0000_0013), instr_valid=0, faults=0, parity_err=0, load_ready=0, busy=1.
//  CLEAR: writes 0 to mem[ptr] each cycle, ptr++; at ptr==DEPTH-1 write, go LOAD with ptr=0.
//  LOAD: load_ready=1; on valid&&ready write mem[ptr]=load_data, ptr++.
//   -> RUN after accepted beat with load_last=1, or accepted beat at ptr==DEPTH-1 (no wrap, no overwrite).
//  RUN: load_ready=0, busy=0; load_start -> LOAD, ptr=0, takes priority over that cycle's fetch.
//  Fetch index = fetch_addr[$clog2(DEPTH)+1:2]; range uses full fetch_addr.
//  Fault or not-RUN: instr=NOP, instr_valid=0; fault flags still reported in any state.
//  Both faults may assert together. REG_READ=1: instr, valid, faults, parity_err all one cycle late, aligned.
//  REG_READ=0: outputs combinational from fetch_addr and current state/memory.
//  Write in LOAD and fetch of same word same cycle: not valid (state != RUN), no bypass required.
//  Reset mid-LOAD/CLEAR: abort, restart per reset rule; memory contents undefined until CLEAR completes.
// CONFIGURATION
//  IMEM_PARITY_EN defined: each word stores XLEN+1 bits; even parity bit computed on every write
//   (CLEAR and LOAD); on fetch in RUN, mismatch -> parity_err=1, instr=NOP, instr_valid=0.
//  IMEM_PARITY_EN undefined: XLEN-bit storage, parity_err tied 0; port list unchanged.
// STRUCTURE
//  Package imem_pkg: imem_state_e {CLEAR, LOAD, RUN}, localparam NOP_INSTR=32'h0000_0013,
//   imem_fetch_s struct {instr, valid, misalign, range, parity_err}.
//  Sub-module imem_array: storage, one write port, one async read port, parity gen/check under macro.
//  Top holds FSM, ptr counter, address decode, optional output register.
// TESTING
//  Reset, CLEAR_ON_RESET=1 -> busy=1 for 64 cycles, load_ready rises cycle 65; fetch 0x0 in LOAD -> NOP, valid=0.
//  Load 6 words (add/add/lw/bne/addi/beq encodings), load_last on 6th -> RUN; fetch 0x0,0x4..0x14 returns them, valid=1; 0x18 -> 0.
//  fetch_addr=0x6 -> fault_misalign=1, instr=NOP; 0x100 (DEPTH=64) -> fault_range=1; 0x102 -> both flags.
//  Stream 70 beats, no load_last -> 64 accepted, RUN entered, load_ready=0 for beats 65-70; word 63 = beat 64.
//  REG_READ=1: fetch 0x8 at cycle n -> instr at n+1; load_start in RUN with fetch -> valid=0, reload overwrites word 0.
//  IMEM_PARITY_EN: force-flip bit 3 of stored word 2, fetch 0x8 -> parity_err=1, instr=NOP; other words clean.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the loadable instruction memory
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        misalign;
    logic        range;
    logic        parity_err;
  } imem_fetch_s;

  localparam imem_fetch_s FETCH_RST = '{
    instr:      NOP_INSTR,
    valid:      1'b0,
    misalign:   1'b0,
    range:      1'b0,
    parity_err: 1'b0
  };

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word storage with one write port and one async read port
// IMEM_PARITY_EN adds an even-parity bit per word, generated on write and checked on read.
module imem_array #(
  parameter int DEPTH = 64,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata,
  output logic                     parity_err
);

`ifdef IMEM_PARITY_EN
  logic [XLEN:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {^wdata, wdata};
  end

  // Stored word plus its parity bit must XOR to zero when intact.
  assign rdata      = mem[raddr][XLEN-1:0];
  assign parity_err = ^mem[raddr];
`else
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata      = mem[raddr];
  assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - run-time loadable instruction memory with byte-addressed fetch
// Stored-word parity checking is enabled by defining IMEM_PARITY_EN.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int REG_READ       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [XLEN-1:0]   instr,
  output logic              instr_valid,
  output logic              fault_misalign,
  output logic              fault_range,
  output logic              parity_err,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [XLEN-1:0]   load_data,
  input  logic              load_last,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam imem_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : LOAD;

  imem_state_e      state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             we;
  logic [XLEN-1:0]  wdata;
  logic [XLEN-1:0]  rdata;
  logic             rd_perr;
  logic             misalign, out_of_range, fetch_ok;
  imem_fetch_s      fetch_d, fetch_q;

  imem_array #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_array (
    .clk        (clk),
    .we         (we),
    .waddr      (ptr_q),
    .wdata      (wdata),
    .raddr      (fetch_addr[IDX_W+1:2]),
    .rdata      (rdata),
    .parity_err (rd_perr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    we         = 1'b0;
    wdata      = '0;
    load_ready = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == LAST_IDX) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          we    = 1'b1;
          wdata = load_data;
          ptr_d = ptr_q + IDX_W'(1);
          // A full array ends the load rather than wrapping onto word 0.
          if (load_last || ptr_q == LAST_IDX) begin
            state_d = RUN;
            ptr_d   = '0;
          end
        end
      end
      RUN: begin
        busy = 1'b0;
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase
    if (reset) begin
      we         = 1'b0;
      load_ready = 1'b0;
      busy       = 1'b1;
    end
  end

  // Power-of-two depth: any set bit above the index field is out of range.
  assign misalign     = |fetch_addr[1:0];
  assign out_of_range = |fetch_addr[ADDR_W-1:IDX_W+2];
  assign fetch_ok     = (state_q == RUN) && !load_start && !misalign && !out_of_range;

  always_comb begin
    fetch_d = FETCH_RST;
    if (!reset) begin
      fetch_d.misalign   = misalign;
      fetch_d.range      = out_of_range;
      fetch_d.parity_err = fetch_ok && rd_perr;
      fetch_d.valid      = fetch_ok && !rd_perr;
      if (fetch_ok && !rd_perr) fetch_d.instr = 32'(rdata);
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      always_ff @(posedge clk) begin
        if (reset) fetch_q <= FETCH_RST;
        else       fetch_q <= fetch_d;
      end
    end else begin : g_comb_read
      always_comb fetch_q = fetch_d;
    end
  endgenerate

  assign instr          = XLEN'(fetch_q.instr);
  assign instr_valid    = fetch_q.valid;
  assign fault_misalign = fetch_q.misalign;
  assign fault_range    = fetch_q.range;
  assign parity_err     = fetch_q.parity_err;

endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - scoreboard bench for combinational and registered fetch builds
// Parity fault injection runs only when IMEM_PARITY_EN is defined.
module tb_imem_loadable;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_addr = 32'h6;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] load_data = '0;

  logic [31:0] instr, r_instr;
  logic        instr_valid, fault_misalign, fault_range, parity_err, load_ready, busy;
  logic        r_valid, r_mis, r_rng, r_perr, r_load_ready, r_busy;
  logic [35:0] c_bus, r_bus;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_mem [64];
  logic        run = 1'b0;
  int          bad_idx = -1;
  int          mptr = 0;
  int          cnt;
  int          accepted;
  logic [35:0] sb [$];

  always #5 clk = ~clk;

  imem_loadable #(.REG_READ(0)) dut (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .instr(instr),
    .instr_valid(instr_valid), .fault_misalign(fault_misalign), .fault_range(fault_range),
    .parity_err(parity_err), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last), .busy(busy)
  );

  imem_loadable #(.REG_READ(1)) dut_r (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .instr(r_instr),
    .instr_valid(r_valid), .fault_misalign(r_mis), .fault_range(r_rng),
    .parity_err(r_perr), .load_start(load_start), .load_valid(load_valid),
    .load_ready(r_load_ready), .load_data(load_data), .load_last(load_last), .busy(r_busy)
  );

  assign c_bus = {instr, instr_valid, fault_misalign, fault_range, parity_err};
  assign r_bus = {r_instr, r_valid, r_mis, r_rng, r_perr};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [31:0] a, input logic ls);
    logic       mis, rng, ok, perr;
    logic [5:0] idx;
    mis  = a[1:0] != 2'b00;
    rng  = a >= 32'h100;
    idx  = a[7:2];
    ok   = run && !ls && !mis && !rng;
    perr = ok && (int'(idx) == bad_idx);
    return {(ok && !perr) ? exp_mem[idx] : NOP_INSTR, ok && !perr, mis, rng, perr};
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic fetch_check(input logic [31:0] a, input logic ls);
    logic [35:0] e;
    fetch_addr = a;
    load_start = ls;
    e = model(a, ls);
    #4;
    check("fetch", 64'(c_bus), 64'(e));
    if (sb.size() > 0) check("reg_fetch", 64'(r_bus), 64'(sb.pop_front()));
    sb.push_back(e);
    @(posedge clk); #1;
    load_start = 1'b0;
    if (ls) run = 1'b0;
  endtask

  task automatic drain();
    #4;
    while (sb.size() > 0) check("reg_fetch", 64'(r_bus), 64'(sb.pop_front()));
    @(posedge clk); #1;
  endtask

  task automatic load_beat(input logic [31:0] d, input logic last, input logic exp_rdy);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    #4;
    check("load_ready", 64'(load_ready), 64'(exp_rdy));
    if (load_ready) accepted++;
    if (exp_rdy) begin
      exp_mem[mptr] = d;
      if (last || mptr == 63) begin
        run  = 1'b1;
        mptr = 0;
      end else begin
        mptr++;
      end
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;

    // Reset state, with a misaligned address that must not raise a fault.
    repeat (3) @(posedge clk);
    #5;
    check("reset_busy", 64'(busy), 64'(1));
    check("reset_load_ready", 64'(load_ready), 64'(0));
    check("reset_fetch", 64'(c_bus), 64'({NOP_INSTR, 4'b0000}));
    check("reset_reg_fetch", 64'(r_bus), 64'({NOP_INSTR, 4'b0000}));
    @(posedge clk); #1;
    reset = 1'b0;
    fetch_addr = 32'h0;

    // CLEAR phase length.
    cnt = 0;
    while (cnt < 200) begin
      #4;
      if (load_ready || !busy) break;
      cnt++;
      @(posedge clk); #1;
    end
    check("clear_cycles", 64'(cnt), 64'(64));
    check("load_busy", 64'(busy), 64'(1));
    check("fetch_in_load", 64'(c_bus), 64'(model(32'h0, 1'b0)));
    @(posedge clk); #1;

    // Six-word program ending with load_last.
    accepted = 0;
    load_beat(32'h003100B3, 1'b0, 1'b1);
    load_beat(32'h00108233, 1'b0, 1'b1);
    load_beat(32'h00022283, 1'b0, 1'b1);
    load_beat(32'h00029463, 1'b0, 1'b1);
    load_beat(32'h00100313, 1'b0, 1'b1);
    load_beat(32'hFE000EE3, 1'b1, 1'b1);
    #4;
    check("run_busy", 64'(busy), 64'(0));
    check("run_load_ready", 64'(load_ready), 64'(0));
    @(posedge clk); #1;

    sb.delete();
    for (int a = 0; a <= 32'h18; a += 4) fetch_check(32'(a), 1'b0);
    fetch_check(32'h6, 1'b0);
    fetch_check(32'hFC, 1'b0);
    fetch_check(32'h100, 1'b0);
    fetch_check(32'h102, 1'b0);
    fetch_check(32'h8, 1'b0);
    fetch_check(32'h8, 1'b1);
    drain();

    // Overlong stream without load_last: array fills, then the stream is refused.
    accepted = 0;
    for (int i = 0; i < 70; i++) load_beat(32'hA500_0000 + 32'(i), 1'b0, i < 64);
    check("stream_accepted", 64'(accepted), 64'(64));
    #4;
    check("stream_run_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;

    sb.delete();
    fetch_check(32'h0, 1'b0);
    fetch_check(32'h8, 1'b0);
    fetch_check(32'hFC, 1'b0);
    fetch_check(32'h100, 1'b0);
    drain();

`ifdef IMEM_PARITY_EN
    dut.u_array.mem[2] = dut.u_array.mem[2] ^ 33'h8;
    dut_r.u_array.mem[2] = dut_r.u_array.mem[2] ^ 33'h8;
    bad_idx = 2;
    sb.delete();
    fetch_check(32'h8, 1'b0);
    fetch_check(32'hC, 1'b0);
    fetch_check(32'h4, 1'b0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
